// File: rtl/mdb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdb_pkg
//  Description : Shared definitions for the multi-drop bus master: destination
//                codes, controller state encoding, the request record layout
//                and the destination-to-enable decode.
//  Revision    : 1.0  initial release
// ============================================================================
package mdb_pkg;

  localparam logic [1:0] DEST_A       = 2'd0;
  localparam logic [1:0] DEST_B       = 2'd1;
  localparam logic [1:0] DEST_C       = 2'd2;
  localparam logic [1:0] DEST_INVALID = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Request record at the default payload width. The FIFO stores the same
  // layout, {dest, data}, generalised to the master's DW.
  localparam int REQ_DW = 8;

  typedef struct packed {
    logic [1:0]        dest;
    logic [REQ_DW-1:0] data;
  } req_t;

  // One-hot {enc, enb, ena}; the invalid code maps to no enable at all.
  function automatic logic [2:0] dest_onehot(input logic [1:0] dest);
    case (dest)
      DEST_A:  return 3'b001;
      DEST_B:  return 3'b010;
      DEST_C:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdb_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mdb_req_fifo
//  Description : Synchronous first-word-fall-through request FIFO.
//                Ports: clk, rst (sync, active-high); push/wdata write side;
//                pop/rdata read side (rdata is the current head); full,
//                empty and level (0..DEPTH) status.
//                Push is ignored while full, pop is ignored while empty.
//  Revision    : 1.0  initial release
// ============================================================================
module mdb_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_en;
  logic          pop_en;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; stale entries are unreachable once the
  // pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_drop_master.sv
`default_nettype none
// ============================================================================
//  Module      : multi_drop_master
//  Description : Upstream driver for the multi-drop bus. Buffers write
//                requests in a FIFO and issues each as one bus cycle with a
//                single drop enable, enforcing GAP_CYCLES idle cycles between
//                transfers.
//                Ports: clk, rst (sync, active-high);
//                in_valid/in_ready/in_dest/in_data request handshake;
//                bus, ena, enb, enc registered bus outputs;
//                busy, err_dest (one-cycle pulse), level (FIFO occupancy).
//  Revision    : 1.0  initial release
// ============================================================================
module multi_drop_master
  import mdb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 0,
  parameter int DW         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_dest,
  input  logic [DW-1:0]          in_data,
  output logic [DW-1:0]          bus,
  output logic                   ena,
  output logic                   enb,
  output logic                   enc,
  output logic                   busy,
  output logic                   err_dest,
  output logic [$clog2(DEPTH):0] level
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SEND = SEND;
  localparam logic [1:0] ST_GAP  = GAP;

  // Counter holds at most GAP_CYCLES-1.
  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [1:0]    state;
  logic [CW-1:0] gap_cnt;
  logic [2:0]    en;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic [DW+1:0] head;
  logic [1:0]    head_dest;
  logic [DW-1:0] head_data;

  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && (in_dest != DEST_INVALID);
  assign head_dest = head[DW+1:DW];
  assign head_data = head[DW-1:0];
  assign busy      = !empty || (state != ST_IDLE);
  assign ena       = en[0];
  assign enb       = en[1];
  assign enc       = en[2];

  mdb_req_fifo #(
    .DEPTH (DEPTH),
    .W     (DW + 2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_dest, in_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // The last gap cycle also makes the IDLE decision, so a waiting request
  // launches with exactly GAP_CYCLES idle cycles after the previous one.
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_IDLE: pop = !empty;
      ST_SEND: pop = (GAP_CYCLES == 0) && !empty;
      ST_GAP:  pop = (gap_cnt == '0) && !empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gap_cnt  <= '0;
      bus      <= '0;
      en       <= 3'b000;
      err_dest <= 1'b0;
    end else begin
      err_dest <= accept && (in_dest == DEST_INVALID);

      // Enables are single-cycle; bus only moves when a new entry launches.
      en <= 3'b000;
      if (pop) begin
        bus <= head_data;
        en  <= dest_onehot(head_dest);
      end

      case (state)
        ST_IDLE: begin
          if (pop) begin
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (GAP_CYCLES == 0) begin
            if (!pop) begin
              state <= ST_IDLE;
            end
          end else begin
            state   <= ST_GAP;
            gap_cnt <= CW'(GAP_CYCLES - 1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= pop ? ST_SEND : ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_drop_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_drop_master
//  Description : Directed self-checking bench. u_dut0 runs with GAP_CYCLES=0
//                (latency, back-to-back, invalid destination); u_dut3 runs
//                with GAP_CYCLES=3 (fill/backpressure, spacing, reset abort).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_drop_master;

  logic       clk;
  logic       rst;

  logic       v0, v3;
  logic [1:0] dest0, dest3;
  logic [7:0] data0, data3;
  logic       rdy0, rdy3;
  logic [7:0] bus0, bus3;
  logic       ena0, enb0, enc0, ena3, enb3, enc3;
  logic       busy0, busy3;
  logic       err0, err3;
  logic [2:0] lvl0, lvl3;
  logic [2:0] en0, en3;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [2:0] mon_en  [$];
  logic [7:0] mon_bus [$];
  int         mon_cyc [$];

  assign en0 = {enc0, enb0, ena0};
  assign en3 = {enc3, enb3, ena3};

  multi_drop_master #(.DEPTH(4), .GAP_CYCLES(0), .DW(8)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_dest(dest0),
    .in_data(data0), .bus(bus0), .ena(ena0), .enb(enb0), .enc(enc0),
    .busy(busy0), .err_dest(err0), .level(lvl0)
  );

  multi_drop_master #(.DEPTH(4), .GAP_CYCLES(3), .DW(8)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_dest(dest3),
    .in_data(data3), .bus(bus3), .ena(ena3), .enb(enb3), .enc(enc3),
    .busy(busy3), .err_dest(err3), .level(lvl3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every transfer u_dut3 puts on the bus.
  always @(negedge clk) begin
    if (en3 != 3'b000) begin
      mon_en.push_back(en3);
      mon_bus.push_back(bus3);
      mon_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] oh(input logic [1:0] d);
    return 3'b001 << d;
  endfunction

  logic [1:0] t2_dest [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
  logic [7:0] t2_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [2:0] t2_en   [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
  logic [7:0] t2_bus  [6] = '{8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
  logic [2:0] t2_lvl  [6] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0};

  logic [1:0] r_dest [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
  logic [7:0] r_data [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};

  initial begin
    int n_before;
    rst = 1'b1;
    v0 = 1'b0; dest0 = 2'd0; data0 = 8'h00;
    v3 = 1'b0; dest3 = 2'd0; data3 = 8'h00;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst_bus", bus0, 8'h00);
    check("rst_en", en0, 3'b000);
    check("rst_err", err0, 1'b0);
    check("rst_lvl", lvl0, 3'd0);
    check("rst_rdy", rdy0, 1'b1);
    check("rst_busy", busy0, 1'b0);

    // Single request, dest B: enable two clocks after the handshake
    v0 = 1'b1; dest0 = 2'd1; data0 = 8'h5A;
    tick();
    v0 = 1'b0;
    check("t1_lvl_e0", lvl0, 3'd1);
    check("t1_en_e0", en0, 3'b000);
    check("t1_busy_e0", busy0, 1'b1);
    tick();
    check("t1_en_e1", en0, 3'b010);
    check("t1_bus_e1", bus0, 8'h5A);
    check("t1_lvl_e1", lvl0, 3'd0);
    tick();
    check("t1_en_e2", en0, 3'b000);
    check("t1_bus_hold", bus0, 8'h5A);
    check("t1_busy_e2", busy0, 1'b0);

    // Back-to-back transfers with no gap
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        v0 = 1'b1; dest0 = t2_dest[k]; data0 = t2_data[k];
      end else begin
        v0 = 1'b0;
      end
      tick();
      check($sformatf("t2_en_%0d", k), en0, t2_en[k]);
      check($sformatf("t2_bus_%0d", k), bus0, t2_bus[k]);
      check($sformatf("t2_lvl_%0d", k), lvl0, t2_lvl[k]);
    end

    // Invalid destination is dropped with a one-cycle error pulse
    v0 = 1'b1; dest0 = 2'd3; data0 = 8'hFF;
    tick();
    v0 = 1'b0;
    check("t3_err", err0, 1'b1);
    check("t3_en", en0, 3'b000);
    check("t3_lvl", lvl0, 3'd0);
    check("t3_bus", bus0, 8'h44);
    check("t3_rdy", rdy0, 1'b1);
    tick();
    check("t3_err_clr", err0, 1'b0);
    check("t3_en2", en0, 3'b000);
    check("t3_bus2", bus0, 8'h44);
    check("t3_busy", busy0, 1'b0);

    // Fill with GAP_CYCLES=3: backpressure, full+pop edge, order and spacing
    mon_en.delete(); mon_bus.delete(); mon_cyc.delete();
    for (int k = 0; k < 5; k++) begin
      v3 = 1'b1; dest3 = r_dest[k]; data3 = r_data[k];
      tick();
    end
    check("t4_lvl_full", lvl3, 3'd4);
    check("t4_rdy_full", rdy3, 1'b0);
    dest3 = r_dest[5]; data3 = r_data[5];
    tick();
    check("t4_lvl_poponly", lvl3, 3'd3);
    check("t4_rdy_after", rdy3, 1'b1);
    check("t4_en_r2", en3, oh(r_dest[1]));
    check("t4_bus_r2", bus3, r_data[1]);
    tick();
    v3 = 1'b0;
    check("t4_lvl_refill", lvl3, 3'd4);
    repeat (20) tick();
    check("t4_busy_end", busy3, 1'b0);
    check("t4_lvl_end", lvl3, 3'd0);
    check("t4_count", mon_en.size(), 6);
    for (int i = 0; i < 6 && i < mon_en.size(); i++) begin
      check($sformatf("t4_ord_en_%0d", i), mon_en[i], oh(r_dest[i]));
      check($sformatf("t4_ord_bus_%0d", i), mon_bus[i], r_data[i]);
      if (i > 0) begin
        check($sformatf("t4_space_%0d", i), mon_cyc[i] - mon_cyc[i-1], 4);
      end
    end

    // Reset while in SEND with 3 entries queued
    mon_en.delete(); mon_bus.delete(); mon_cyc.delete();
    for (int k = 0; k < 5; k++) begin
      v3 = 1'b1; dest3 = 2'(k % 3); data3 = 8'h60 + 8'(k);
      tick();
    end
    v3 = 1'b0;
    tick();
    check("t5_en_send", en3, 3'b010);
    check("t5_lvl_send", lvl3, 3'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_en", en3, 3'b000);
    check("t5_bus", bus3, 8'h00);
    check("t5_lvl", lvl3, 3'd0);
    check("t5_rdy", rdy3, 1'b1);
    check("t5_busy", busy3, 1'b0);
    n_before = mon_en.size();
    check("t5_pre_count", n_before, 2);
    repeat (15) tick();
    check("t5_no_stale", mon_en.size(), n_before);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_drop_master.md
Name: multi_drop_master

Overview:
- Upstream driver for the multi-drop bus.
- Accepts write requests (destination id + byte) over a valid/ready interface and buffers them in a small FIFO.
- Issues each request as one bus cycle: data on `bus`, exactly one of `ena`/`enb`/`enc` high.
- Enforces a configurable minimum idle gap between bus transfers.

Parameters:
- DEPTH, 4, request FIFO depth in entries; power of two, ≥2.
- GAP_CYCLES, 0, forced idle cycles (all enables low) after each transfer; 0 allows back-to-back transfers.
- DW, 8, bus/data width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request can be accepted; equals !full
- in_dest  input  2  destination: 0=A, 1=B, 2=C, 3=invalid
- in_data  input  DW  payload byte
- bus  output  DW  registered bus data
- ena  output  1  registered write enable, drop A
- enb  output  1  registered write enable, drop B
- enc  output  1  registered write enable, drop C
- busy  output  1  FIFO non-empty or state != IDLE
- err_dest  output  1  one-cycle pulse, invalid destination dropped
- level  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset (synchronous, active-high):
  - bus=0; ena=enb=enc=0; err_dest=0.
  - FIFO flushed; level=0; in_ready=1; state=IDLE; gap counter=0.
  - Reset mid-transfer or mid-gap aborts immediately; queued requests are discarded.
- Handshake and enqueue:
  - Transfer occurs on an edge where in_valid && in_ready.
  - in_dest 0..2: the entry {dest, data} is pushed.
  - in_dest==3: handshake completes, nothing is pushed, err_dest=1 for the following cycle only.
- in_ready = !full, from registered occupancy. No push while full, even if a pop occurs on the same edge.
- Push and pop on the same edge are both performed; level is unchanged.
- FIFO pointers wrap modulo DEPTH. level counts 0..DEPTH.
- State machine (registered):
  - IDLE: if FIFO non-empty at the edge, pop head, load bus=data, assert the one-hot enable for head.dest -> SEND. Otherwise all enables 0 and bus holds its last value.
  - SEND: enable is high for exactly one cycle.
    - GAP_CYCLES==0 and FIFO non-empty: pop the next entry (back-to-back) and stay in SEND.
    - GAP_CYCLES==0 and FIFO empty: deassert enables -> IDLE.
    - GAP_CYCLES>0: deassert enables, load counter=GAP_CYCLES-1 -> GAP.
  - GAP: enables 0, bus holds; counter decrements each cycle; at counter==0 -> IDLE.
- Latency: request accepted at edge E0 into an empty FIFO with state IDLE -> enable and data visible in the cycle after edge E1 (2 clocks from handshake to bus).
- Throughput: 1 transfer/cycle with GAP_CYCLES=0; 1 per (1+GAP_CYCLES) cycles otherwise.
- Invariant: at most one of ena/enb/enc is high in any cycle. bus changes only on edges that assert an enable, or on reset.
- Order is strict FIFO; no reordering by destination.

Decomposition:
- Package `mdb_pkg`:
  - DEST_A=2'd0, DEST_B=2'd1, DEST_C=2'd2, DEST_INVALID=2'd3.
  - State enum {IDLE, SEND, GAP}.
  - Request struct {dest[1:0], data[DW-1:0]}.
- Sub-module `mdb_req_fifo`: synchronous FIFO with push/pop/full/empty/level and synchronous reset. The top level contains the FSM, gap counter, one-hot decode and output registers.

Test Plan:
- Reset, then a single request dest=1, data=0x5A -> 2 clocks later enb=1 and bus=0x5A for one cycle; ena=enc=0; busy falls afterwards.
- GAP_CYCLES=0, four back-to-back requests (0,0x11), (1,0x22), (2,0x33), (0,0x44) -> enables a,b,c,a on 4 consecutive cycles with matching bus values; level peaks at 2 or less.
- DEPTH=4, hold the drain with GAP_CYCLES=3 and push 6 requests -> in_ready drops at level=4; accepted order is preserved; each transfer is separated by exactly 3 idle cycles.
- Request with dest=3, data=0xFF -> err_dest=1 for one cycle; no enable asserts; level stays 0; bus unchanged.
- Assert rst for 1 cycle while in SEND with 3 entries queued -> next cycle all enables 0, bus=0, level=0, in_ready=1; no stale transfer appears afterwards.
- Push while full and pop on the same edge (level=4, in_valid=1) -> push rejected (in_ready=0), level becomes 3, then accepted on the following edge.
